// File: rtl/mem_responder.sv
// mem_responder: word-wide memory bus responder with programmable wait states,
// backed by an internal synchronous word RAM. Completion is signalled with a
// one-cycle ready pulse; ready is also high while idle with no request so that
// non-memory steps of the control unit are never stalled.
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oRdy,
  output logic        oErr
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES > 255) begin : g_bad_wait
    $error("mem_responder: WAIT_CYCLES must be in 0..255");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 31) begin : g_bad_addr
    $error("mem_responder: ADDR_BITS must be in 1..31");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;

  logic [31:0]          mem [DEPTH];
  logic                 req;
  logic                 fault;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] idx;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  assign req   = iMemRead | iMemWrite;
  assign idx   = addr_q[ADDR_BITS-1:0];
  // Fault is judged only on the latched request, never on live inputs.
  assign fault = (rd_q & wr_q) | ((addr_q >> ADDR_BITS) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rd_d    = iMemRead;
          wr_d    = iMemWrite;
          addr_d  = iAddr;
          wdata_d = iData;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACCESS: begin
        if (!fault) begin
          ram_we = wr_q;
          if (rd_q) begin
            rdata_d = mem[idx];
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM write port; a reset at the access edge wins over the write.
  always_ff @(posedge iClk) begin
    if (ram_we && !iRst) begin
      mem[idx] <= wdata_q;
    end
  end

  assign oData = rdata_q;
  assign oRdy  = !iRst && (((state_q == S_IDLE) && !req) || (state_q == S_DONE));
  assign oErr  = !iRst && (state_q == S_DONE) && fault;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=0. Stimulus pushes expected completions; monitors pop and
// compare whenever a request completes (ready seen with request high).
module tb_mem_responder;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        rst_a, rd_a, wr_a, rdy_a, err_a;
    logic [31:0] addr_a, wd_a, data_a;
    logic        rst_b, rd_b, wr_b, rdy_b, err_b;
    logic [31:0] addr_b, wd_b, data_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic prev_rdy_a = 1'b0;
    logic prev_rdy_b = 1'b0;

    mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) u_a (
        .iClk(clk), .iRst(rst_a), .iMemRead(rd_a), .iMemWrite(wr_a),
        .iAddr(addr_a), .iData(wd_a), .oData(data_a), .oRdy(rdy_a), .oErr(err_a)
    );

    mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_b (
        .iClk(clk), .iRst(rst_b), .iMemRead(rd_b), .iMemWrite(wr_b),
        .iAddr(addr_b), .iData(wd_b), .oData(data_b), .oRdy(rdy_b), .oErr(err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor A: every completion is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst_a && rdy_a && (rd_a || wr_a)) begin
            chk("a_no_back_to_back", {31'd0, prev_rdy_a}, 32'd0);
            if (q_a.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected_rdy: got ready with empty scoreboard (cycle %0d)", cyc);
            end else begin
                ea = q_a.pop_front();
                chk("a_latency", 32'(cyc), 32'(ea.cyc));
                chk("a_data", data_a, ea.data);
                chk("a_err", {31'd0, err_a}, {31'd0, ea.err});
            end
        end
        prev_rdy_a <= rdy_a;
    end

    // Monitor B: same checks for the zero-wait instance.
    always @(negedge clk) begin
        if (!rst_b && rdy_b && (rd_b || wr_b)) begin
            chk("b_no_back_to_back", {31'd0, prev_rdy_b}, 32'd0);
            if (q_b.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected_rdy: got ready with empty scoreboard (cycle %0d)", cyc);
            end else begin
                eb = q_b.pop_front();
                chk("b_latency", 32'(cyc), 32'(eb.cyc));
                chk("b_data", data_b, eb.data);
                chk("b_err", {31'd0, err_b}, {31'd0, eb.err});
            end
        end
        prev_rdy_b <= rdy_b;
    end

    // Bounded wait for a completion on the selected instance.
    task automatic wait_done(input bit sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel ? (rdy_b && (rd_b || wr_b)) : (rdy_a && (rd_a || wr_a))) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no ready within 40 cycles expected ready", sel ? "b" : "a");
            if (sel) q_b.delete(); else q_a.delete();
        end
    endtask

    // One complete transaction, held until ready, expectation pushed first.
    task automatic txn(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        @(posedge clk); #1;
        e.cyc  = cyc + (sel ? 0 : 2) + 2;
        e.data = exp_data;
        e.err  = exp_err;
        if (sel) begin
            q_b.push_back(e);
            rd_b = rd; wr_b = wr; addr_b = addr; wd_b = data;
        end else begin
            q_a.push_back(e);
            rd_a = rd; wr_a = wr; addr_a = addr; wd_a = data;
        end
        wait_done(sel);
        @(posedge clk); #1;
        if (sel) begin
            rd_b = 1'b0; wr_b = 1'b0; addr_b = $urandom; wd_b = $urandom;
        end else begin
            rd_a = 1'b0; wr_a = 1'b0; addr_a = $urandom; wd_a = $urandom;
        end
    endtask

    initial begin
        exp_t e;
        int   t0;
        rst_a = 1'b1; rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wd_a = '0;
        rst_b = 1'b1; rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wd_b = '0;

        // Reset held: ready forced low, no error.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy_a", {31'd0, rdy_a}, 32'd0);
        chk("rst_rdy_b", {31'd0, rdy_b}, 32'd0);
        chk("rst_err_a", {31'd0, err_a}, 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("idle_rdy_a", {31'd0, rdy_a}, 32'd1);
        chk("idle_err_a", {31'd0, err_a}, 32'd0);
        chk("idle_data_a", data_a, 32'd0);
        chk("idle_rdy_b", {31'd0, rdy_b}, 32'd1);

        // Write then read back, data held after deassert.
        txn(1'b0, 1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 32'h5, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("a_data_hold", data_a, 32'hDEADBEEF);

        // Out-of-range address: error, no aliasing into RAM[0], oData kept.
        txn(1'b0, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 1'b1);
        txn(1'b0, 1'b0, 1'b1, 32'h400, 32'h00000055, 32'hDEADBEEF, 1'b1);
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);

        // Read and write both high: error, no write.
        txn(1'b0, 1'b0, 1'b1, 32'h3, 32'h0BADF00D, 32'hA5A5A5A5, 1'b0);
        txn(1'b0, 1'b1, 1'b1, 32'h3, 32'h00001234, 32'hA5A5A5A5, 1'b1);
        txn(1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 32'h0BADF00D, 1'b0);

        // Reset during WAIT aborts the write.
        txn(1'b0, 1'b0, 1'b1, 32'h7, 32'h11111111, 32'h0BADF00D, 1'b0);
        @(posedge clk); #1;
        wr_a = 1'b1; addr_a = 32'h7; wd_a = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst_a = 1'b1; wr_a = 1'b0;
        @(negedge clk);
        chk("a_rst_wait_rdy_low", {31'd0, rdy_a}, 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("a_rst_wait_idle_rdy", {31'd0, rdy_a}, 32'd1);
        chk("a_rst_wait_data", data_a, 32'd0);
        txn(1'b0, 1'b1, 1'b0, 32'h7, 32'h0, 32'h11111111, 1'b0);

        // Reset at the ACCESS edge suppresses the write.
        @(posedge clk); #1;
        wr_a = 1'b1; addr_a = 32'h7; wd_a = 32'hCAFEF00D;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_a = 1'b1; wr_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("a_rst_access_idle_rdy", {31'd0, rdy_a}, 32'd1);
        chk("a_rst_access_err", {31'd0, err_a}, 32'd0);
        txn(1'b0, 1'b1, 1'b0, 32'h7, 32'h0, 32'h11111111, 1'b0);

        // Zero-wait instance: preload, then a read held across two transactions.
        txn(1'b1, 1'b0, 1'b1, 32'h10, 32'h01020304, 32'h0, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 32'h11, 32'h0A0B0C0D, 32'h0, 1'b0);
        @(posedge clk); #1;
        t0 = cyc;
        e.cyc = t0 + 2; e.data = 32'h01020304; e.err = 1'b0;
        q_b.push_back(e);
        rd_b = 1'b1; addr_b = 32'h10;
        wait_done(1'b1);
        addr_b = 32'h11;
        e.cyc = t0 + 5; e.data = 32'h0A0B0C0D; e.err = 1'b0;
        q_b.push_back(e);
        wait_done(1'b1);
        @(posedge clk); #1;
        rd_b = 1'b0;
        repeat (2) @(negedge clk);

        chk("a_scoreboard_drained", 32'(q_a.size()), 32'd0);
        chk("b_scoreboard_drained", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
